// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller.
// Big-endian lanes: lane 0 occupies bits 31:24.
package mem_ctrl_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = LANES * BYTE_W;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StRmwRd  = 2'd2,
        StRmwWr  = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        OP_READ = 2'd0,
        OP_SWL  = 2'd1,
        OP_SWR  = 2'd2
    } mem_op_t;

    // Lanes a partial store overwrites; {b, 3'b000} is the byte offset in bits.
    function automatic logic [WORD_W-1:0] lane_mask(mem_op_t op, logic [1:0] b);
        logic [WORD_W-1:0] mask;
        case (op)
            OP_SWL:  mask = {WORD_W{1'b1}} >> {b, 3'b000};
            OP_SWR:  mask = {WORD_W{1'b1}} << {~b, 3'b000};
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Processor data-port bus between the core (master) and the memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0] Address;
    logic              ReadEn;
    logic              WriteEn;
    logic              WriteL;
    logic              WriteR;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              nStall;

    modport master (
        output Address,
        output ReadEn,
        output WriteEn,
        output WriteL,
        output WriteR,
        output WriteData,
        input  ReadData,
        input  nStall
    );

    modport slave (
        input  Address,
        input  ReadEn,
        input  WriteEn,
        input  WriteL,
        input  WriteR,
        input  WriteData,
        output ReadData,
        output nStall
    );

endinterface

// File: rtl/byte_merge.sv
// Combinational SWL/SWR merge of store data into the word read back from SRAM.
module byte_merge
    import mem_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] oldWord,
    input  logic [WORD_W-1:0] writeData,
    input  mem_op_t           op,
    input  logic [1:0]        byteSel,
    output logic [WORD_W-1:0] merged
);

    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] aligned;

    always_comb begin
        mask = lane_mask(op, byteSel);
        case (op)
            OP_SWL:  aligned = writeData >> {byteSel, 3'b000};
            OP_SWR:  aligned = writeData << {~byteSel, 3'b000};
            default: aligned = '0;
        endcase
        merged = (oldWord & ~mask) | (aligned & mask);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: core data port to a single-port synchronous SRAM.
// Full writes take one cycle; loads stall one cycle, SWL/SWR two (read-modify-write).
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRAM_AW = 14
) (
    input  logic               Clock,
    input  logic               nReset,
    data_mem_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0] SramAddr,
    output logic               SramCE,
    output logic               SramWE,
    output logic [DATA_W-1:0]  SramWData,
    input  logic [DATA_W-1:0]  SramRData
);

    mem_state_t        stateQ, stateD;
    logic [ADDR_W-1:0] reqAddrQ;
    logic [DATA_W-1:0] reqDataQ;
    mem_op_t           reqOpQ;
    logic [DATA_W-1:0] oldWordQ;
    logic [DATA_W-1:0] readDataQ;

    logic [DATA_W-1:0] mergedWord;
    logic [ADDR_W-1:0] accessAddr;
    mem_op_t           newOp;
    logic              isPartial;
    logic              capture;
    logic              stallReq;

    // WriteL and WriteR together degrade to a plain full-word store.
    assign isPartial = bus.WriteEn & (bus.WriteL ^ bus.WriteR);
    assign newOp     = isPartial ? (bus.WriteL ? OP_SWL : OP_SWR) : OP_READ;

    byte_merge u_byte_merge (
        .oldWord   (oldWordQ),
        .writeData (reqDataQ),
        .op        (reqOpQ),
        .byteSel   (reqAddrQ[1:0]),
        .merged    (mergedWord)
    );

    always_comb begin
        stateD     = stateQ;
        capture    = 1'b0;
        stallReq   = 1'b0;
        SramCE     = 1'b0;
        SramWE     = 1'b0;
        SramWData  = '0;
        accessAddr = '0;
        unique case (stateQ)
            StIdle: begin
                if (bus.WriteEn && !isPartial) begin
                    SramCE     = 1'b1;
                    SramWE     = 1'b1;
                    SramWData  = bus.WriteData;
                    accessAddr = bus.Address;
                end else if (bus.WriteEn || bus.ReadEn) begin
                    // Load or first half of a read-modify-write: fetch the word.
                    capture    = 1'b1;
                    stallReq   = 1'b1;
                    SramCE     = 1'b1;
                    accessAddr = bus.Address;
                    stateD     = isPartial ? StRmwRd : StRdWait;
                end
            end
            StRdWait: begin
                accessAddr = reqAddrQ;
                stateD     = StIdle;
            end
            StRmwRd: begin
                accessAddr = reqAddrQ;
                stallReq   = 1'b1;
                stateD     = StRmwWr;
            end
            StRmwWr: begin
                SramCE     = 1'b1;
                SramWE     = 1'b1;
                SramWData  = mergedWord;
                accessAddr = reqAddrQ;
                stateD     = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stateQ    <= StIdle;
            reqAddrQ  <= '0;
            reqDataQ  <= '0;
            reqOpQ    <= OP_READ;
            oldWordQ  <= '0;
            readDataQ <= '0;
        end else begin
            stateQ <= stateD;
            if (capture) begin
                reqAddrQ <= bus.Address;
                reqDataQ <= bus.WriteData;
                reqOpQ   <= newOp;
            end
            if (stateQ == StRmwRd) begin
                oldWordQ <= SramRData;
            end
            if (stateQ == StRdWait) begin
                readDataQ <= SramRData;
            end
        end
    end

    assign SramAddr     = SRAM_AW'(accessAddr >> 2);
    assign bus.nStall   = ~stallReq;
    // Bypass so the core sees load data in the same cycle it is returned.
    assign bus.ReadData = (stateQ == StRdWait) ? SramRData : readDataQ;

    assert property (@(posedge Clock) disable iff (!nReset) SramWE |-> SramCE);
    assert property (@(posedge Clock) disable iff (!nReset)
                     (stateQ == StRmwRd) |=> (stateQ == StRmwWr));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with an SRAM model and a lane-level memory model.
module tb_data_mem_ctrl;

    localparam int K_READ = 0;
    localparam int K_FULL = 1;
    localparam int K_SWL  = 2;
    localparam int K_SWR  = 3;
    localparam int K_BOTH = 4;
    localparam int K_LR   = 5;

    logic        Clock = 1'b0;
    logic        nReset;
    logic [13:0] SramAddr;
    logic        SramCE;
    logic        SramWE;
    logic [31:0] SramWData;
    logic [31:0] SramRData = '0;

    data_mem_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    data_mem_ctrl #(.ADDR_W(16), .DATA_W(32), .SRAM_AW(14)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .bus       (bus),
        .SramAddr  (SramAddr),
        .SramCE    (SramCE),
        .SramWE    (SramWE),
        .SramWData (SramWData),
        .SramRData (SramRData)
    );

    always #5 Clock = ~Clock;

    logic [31:0] sram [0:16383];
    int          weCount = 0;

    always @(posedge Clock) begin
        if (SramCE && SramWE) begin
            sram[SramAddr] <= SramWData;
            weCount        <= weCount + 1;
        end
        if (SramCE && !SramWE) SramRData <= sram[SramAddr];
    end

    logic [31:0] modelMem [0:16383];
    int          nChecks;
    int          nPass;
    int          opCycle;
    int          curKind;
    int          curLatency;
    logic        active;
    logic [31:0] curExpRead;
    logic [31:0] curExpWord;
    logic [13:0] curWord;
    logic [31:0] lastRead;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // MIPS SWL/SWR expressed lane by lane rather than with masks.
    function automatic logic [31:0] modelStore(input int kind, input logic [31:0] old,
                                               input logic [31:0] wd, input int b);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (kind == K_SWL && l >= b) r[31-8*l -: 8] = wd[31-8*(l-b) -: 8];
            if (kind == K_SWR && l <= b) r[31-8*l -: 8] = wd[31-8*(l+3-b) -: 8];
        end
        return r;
    endfunction

    task automatic cycleCheck();
        logic expNStall;
        logic expWe;
        if (active) begin
            expNStall = (opCycle >= curLatency);
            expWe     = (curKind != K_READ) && (opCycle == curLatency);
            check("nstall", bus.nStall, expNStall);
            check("sram_we", SramWE, expWe);
            if (expWe) begin
                check("sram_wdata", SramWData, curExpWord);
                check("sram_addr", SramAddr, curWord);
            end
            if (curKind == K_READ && expNStall) begin
                check("read_data", bus.ReadData, curExpRead);
                lastRead = curExpRead;
            end else begin
                check("read_hold", bus.ReadData, lastRead);
            end
            opCycle++;
        end else begin
            check("idle_nstall", bus.nStall, 1'b1);
            check("idle_ce", SramCE, 1'b0);
            check("read_hold", bus.ReadData, lastRead);
        end
    endtask

    task automatic deassert();
        bus.ReadEn  = 1'b0;
        bus.WriteEn = 1'b0;
        bus.WriteL  = 1'b0;
        bus.WriteR  = 1'b0;
    endtask

    task automatic idle(input int n);
        @(posedge Clock);
        #1;
        deassert();
        active = 1'b0;
        repeat (n) begin
            @(negedge Clock);
            cycleCheck();
        end
    endtask

    // Drives one request and holds it until nStall is seen high; returns stall count.
    task automatic issue(input int kind, input logic [15:0] addr, input logic [31:0] data,
                         output int stalls);
        int   w;
        logic done;
        w = int'(addr[15:2]);
        @(posedge Clock);
        #1;
        bus.Address   = addr;
        bus.WriteData = data;
        bus.ReadEn    = (kind == K_READ) || (kind == K_BOTH);
        bus.WriteEn   = (kind != K_READ);
        bus.WriteL    = (kind == K_SWL) || (kind == K_LR);
        bus.WriteR    = (kind == K_SWR) || (kind == K_LR);
        curKind       = kind;
        curWord       = addr[15:2];
        curLatency    = (kind == K_READ) ? 1 : ((kind == K_SWL || kind == K_SWR) ? 2 : 0);
        if (kind == K_READ) begin
            curExpRead = modelMem[w];
        end else if (kind == K_SWL || kind == K_SWR) begin
            modelMem[w] = modelStore(kind, modelMem[w], data, int'(addr[1:0]));
        end else begin
            modelMem[w] = data;
        end
        curExpWord = modelMem[w];
        opCycle    = 0;
        active     = 1'b1;
        stalls     = 0;
        done       = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge Clock);
            cycleCheck();
            if (bus.nStall) done = 1'b1;
            else stalls++;
        end
        if (!done) check("stall_timeout", bus.nStall, 1'b1);
    endtask

    initial begin
        int          s;
        int          weBefore;
        logic [15:0] a;
        logic [15:0] touched [$];
        nChecks  = 0;
        nPass    = 0;
        active   = 1'b0;
        lastRead = '0;
        opCycle  = 0;
        for (int i = 0; i < 16384; i++) modelMem[i] = '0;
        bus.Address   = '0;
        bus.WriteData = '0;
        deassert();
        nReset = 1'b0;

        repeat (2) @(posedge Clock);
        #1;
        check("rst_nstall", bus.nStall, 1'b1);
        check("rst_ce", SramCE, 1'b0);
        check("rst_we", SramWE, 1'b0);
        check("rst_addr", SramAddr, 14'd0);
        check("rst_wdata", SramWData, 32'd0);
        check("rst_rdata", bus.ReadData, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;
        idle(2);

        issue(K_FULL, 16'h0010, 32'hDEADBEEF, s);
        check("full_wr_stalls", s, 0);
        issue(K_READ, 16'h0010, 32'h0, s);
        check("read_stalls", s, 1);
        idle(1);
        check("read_deadbeef", bus.ReadData, 32'hDEADBEEF);

        issue(K_FULL, 16'h0020, 32'h11223344, s);
        issue(K_SWL, 16'h0021, 32'hAABBCCDD, s);
        check("swl_stalls", s, 2);
        issue(K_READ, 16'h0020, 32'h0, s);
        idle(1);
        check("swl_b1_dut", bus.ReadData, 32'h11AABBCC);
        check("swl_b1_model", modelMem[8], 32'h11AABBCC);

        issue(K_FULL, 16'h0020, 32'h11223344, s);
        issue(K_SWR, 16'h0022, 32'hAABBCCDD, s);
        check("swr_stalls", s, 2);
        issue(K_READ, 16'h0020, 32'h0, s);
        idle(1);
        check("swr_b2_dut", bus.ReadData, 32'hBBCCDD44);
        check("swr_b2_model", modelMem[8], 32'hBBCCDD44);

        issue(K_FULL, 16'h0040, 32'h01020304, s);
        issue(K_SWL, 16'h0040, 32'hCAFEF00D, s);
        issue(K_FULL, 16'h0044, 32'h01020304, s);
        issue(K_SWR, 16'h0047, 32'h12345678, s);
        issue(K_READ, 16'h0040, 32'h0, s);
        idle(1);
        check("swl_b0_full", bus.ReadData, 32'hCAFEF00D);
        issue(K_READ, 16'h0044, 32'h0, s);
        idle(1);
        check("swr_b3_full", bus.ReadData, 32'h12345678);

        // Every lane offset, back to back with no idle cycles in between.
        for (int b = 0; b < 4; b++) begin
            a = 16'h0050 + 16'(4 * b);
            issue(K_FULL, a, 32'h01020304, s);
            issue(K_SWL, a + 16'(b), 32'hA1B2C3D4, s);
            issue(K_READ, a, 32'h0, s);
            a = 16'h0060 + 16'(4 * b);
            issue(K_FULL, a, 32'h01020304, s);
            issue(K_SWR, a + 16'(b), 32'hA1B2C3D4, s);
            issue(K_READ, a, 32'h0, s);
        end
        check("swl_b2_model", modelMem[16'h0058 >> 2], 32'h0102A1B2);
        check("swr_b1_model", modelMem[16'h0064 >> 2], 32'hC3D40304);

        issue(K_BOTH, 16'h0004, 32'h00000005, s);
        check("both_stalls", s, 0);
        issue(K_READ, 16'h0004, 32'h0, s);
        idle(1);
        check("both_is_write", bus.ReadData, 32'h00000005);

        issue(K_LR, 16'h0008, 32'h87654321, s);
        check("lr_stalls", s, 0);
        issue(K_READ, 16'h0008, 32'h0, s);
        idle(1);
        check("lr_is_full", bus.ReadData, 32'h87654321);

        // Reset in the middle of a partial store: the store must be dropped.
        issue(K_FULL, 16'h0030, 32'h11223344, s);
        @(posedge Clock);
        #1;
        weBefore      = weCount;
        bus.Address   = 16'h0031;
        bus.WriteData = 32'hFFFFFFFF;
        bus.ReadEn    = 1'b0;
        bus.WriteEn   = 1'b1;
        bus.WriteL    = 1'b1;
        bus.WriteR    = 1'b0;
        curKind       = K_SWL;
        curLatency    = 2;
        curWord       = 14'h000C;
        opCycle       = 0;
        active        = 1'b1;
        @(negedge Clock);
        cycleCheck();
        @(posedge Clock);
        #1;
        nReset = 1'b0;
        deassert();
        active   = 1'b0;
        lastRead = '0;
        @(negedge Clock);
        check("rst_mid_nstall", bus.nStall, 1'b1);
        check("rst_mid_rdata", bus.ReadData, 32'd0);
        check("rst_mid_ce", SramCE, 1'b0);
        check("rst_mid_we", SramWE, 1'b0);
        @(negedge Clock);
        nReset = 1'b1;
        idle(3);
        check("rst_no_write", weCount - weBefore, 0);
        check("rst_word_kept_sram", sram[12], 32'h11223344);
        issue(K_READ, 16'h0030, 32'h0, s);
        idle(1);
        check("rst_word_kept_rd", bus.ReadData, 32'h11223344);

        touched = '{16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0044};
        for (int b = 0; b < 4; b++) begin
            touched.push_back(16'h0050 + 16'(4 * b));
            touched.push_back(16'h0060 + 16'(4 * b));
        end
        foreach (touched[i]) begin
            check("sram_contents", sram[touched[i][15:2]], modelMem[touched[i][15:2]]);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
